// File: rtl/log_sample_queue.sv
// Sample queue that buffers acquisition samples and drains them one at a time
// to an SD SPI writer using a launch / acknowledge / done handshake.
module log_sample_queue #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [DATA_W-1:0]        sample_data,
  output logic                     sample_ready,
  output logic                     wr_start,
  output logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic                     ack_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       head, tail;
  logic [TW-1:0]       ack_timer;
  logic                push, drop, pop, load, timeout;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Fullness is judged on the registered count, so a pop on the same edge
  // never makes room for a push into a full queue.
  assign sample_ready = (count != FULL_CNT);
  assign push         = sample_valid && sample_ready;
  assign drop         = sample_valid && !sample_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (count != '0 && !wr_busy) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_ACK;
      WAIT_ACK:  if (wr_busy) state_nxt = WAIT_DONE;
                 else if (ack_timer == TMR_LAST) state_nxt = IDLE;
      WAIT_DONE: if (!wr_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_start = 1'b0;
    load     = 1'b0;
    pop      = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE:      load     = (state_nxt == LAUNCH);
      LAUNCH:    wr_start = 1'b1;
      WAIT_ACK:  timeout  = !wr_busy && (ack_timer == TMR_LAST);
      WAIT_DONE: pop      = !wr_busy;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != WAIT_ACK) ack_timer <= '0;
    else                          ack_timer <= ack_timer + 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= sample_data;
  end

  // The head entry stays in the queue until the writer finishes, so a
  // timed-out launch simply re-reads the same word on the next attempt.
  always_ff @(posedge clk) begin
    if (rst)       wr_data <= '0;
    else if (load) wr_data <= mem[head];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      ack_err    <= 1'b0;
    end else begin
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc16(drop_count);
      end
      if (timeout) ack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_log_sample_queue.sv
// Randomized bench for log_sample_queue: a queue-based reference model, a
// writer model driving wr_busy, and directed checks of the boundary cases.
module tb_log_sample_queue;

  localparam int DATA_W      = 16;
  localparam int DEPTH       = 16;
  localparam int ACK_TIMEOUT = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   sample_valid = 1'b0;
  logic [DATA_W-1:0]      sample_data = '0;
  logic                   sample_ready;
  logic                   wr_start;
  logic [DATA_W-1:0]      wr_data;
  logic                   wr_busy = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [15:0]            drop_count;
  logic                   ack_err;

  log_sample_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(sample_ready), .wr_start(wr_start), .wr_data(wr_data),
    .wr_busy(wr_busy), .count(count), .overflow(overflow),
    .drop_count(drop_count), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DATA_W-1:0] mq[$];
  logic              m_over = 1'b0;
  logic [15:0]       m_drop = '0;
  int                pops_req = 0;
  int                pops_done = 0;
  int                epoch = 0;

  // Writer model controls
  bit                ack_mode = 1'b1;
  bit                rand_timing = 1'b0;
  bit                hold_busy = 1'b0;
  int                ack_delay = 1;
  int                busy_len = 3;
  int                launches = 0;
  bit                active = 1'b0;
  int                act_epoch = 0;
  logic [DATA_W-1:0] cur_word = '0;
  logic [DATA_W-1:0] sent[$];
  logic [DATA_W-1:0] expq[$];
  bit                mon_en = 1'b0;

  // Reference model: plain FIFO rules, full judged before the same-edge pop.
  initial begin
    logic              full;
    logic [DATA_W-1:0] tmp;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_over    = 1'b0;
        m_drop    = '0;
        pops_done = pops_req;
        epoch++;
      end else begin
        full = (mq.size() == DEPTH);
        if (sample_valid && full) begin
          m_over = 1'b1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
        if (pops_done != pops_req) begin
          tmp = mq.pop_front();
          pops_done++;
        end
        if (sample_valid && !full) mq.push_back(sample_data);
      end
    end
  end

  // Writer model: acknowledges a launch after a delay, stays busy, then releases.
  initial begin
    int d, b, my_epoch;
    forever begin
      @(negedge clk);
      if (wr_start === 1'b1) begin
        launches++;
        sent.push_back(wr_data);
        check_eq("launch_q_nonempty", (mq.size() != 0), 1);
        if (mq.size() != 0) check_eq("launch_word", wr_data, mq[0]);
        if (ack_mode) begin
          d = rand_timing ? $urandom_range(ACK_TIMEOUT - 1, 1) : ack_delay;
          b = rand_timing ? $urandom_range(6, 1) : busy_len;
          my_epoch  = epoch;
          act_epoch = epoch;
          cur_word  = wr_data;
          active    = 1'b1;
          repeat (d) @(negedge clk);
          wr_busy = 1'b1;
          repeat (b) @(negedge clk);
          while (hold_busy) @(negedge clk);
          wr_busy = 1'b0;
          active  = 1'b0;
          if (epoch == my_epoch) pops_req++;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check_eq("count", count, mq.size());
        check_eq("sample_ready", sample_ready, (mq.size() < DEPTH));
        check_eq("overflow", overflow, m_over);
        check_eq("drop_count", drop_count, m_drop);
        check_eq("start_while_busy", wr_start & wr_busy, 0);
        if (active && act_epoch == epoch) check_eq("wr_data_hold", wr_data, cur_word);
      end
    end
  end

  task automatic push_word(input logic [DATA_W-1:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((mq.size() != 0 || active || wr_busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_in_time", (n < limit), 1);
  endtask

  task automatic compare_sent();
    check_eq("sent_len", sent.size(), expq.size());
    for (int i = 0; i < sent.size() && i < expq.size(); i++)
      check_eq("sent_order", sent[i], expq[i]);
  endtask

  initial begin
    int l0, n, prev;
    logic [DATA_W-1:0] w;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_count", count, 0);
    check_eq("rst_wr_start", wr_start, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_ack_err", ack_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", sample_ready, 1);
    mon_en = 1'b1;

    // Single word with a long busy period
    sent.delete();
    ack_delay = 1; busy_len = 40;
    l0 = launches;
    push_word(16'hAAAA);
    check_eq("no_early_start", wr_start, 0);
    check_eq("single_count", count, 1);
    wait_idle(200);
    check_eq("single_launches", launches - l0, 1);
    check_eq("single_word", sent[0], 16'hAAAA);
    check_eq("single_count_end", count, 0);

    // Ordering
    sent.delete(); expq.delete();
    busy_len = 3; l0 = launches;
    for (int i = 1; i <= 5; i++) begin
      push_word(DATA_W'(i));
      expq.push_back(DATA_W'(i));
    end
    wait_idle(300);
    check_eq("order_launches", launches - l0, 5);
    compare_sent();

    // Overflow with the writer held busy
    sent.delete(); expq.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      push_word(DATA_W'(16'h0100 + i));
      if (i < DEPTH) expq.push_back(DATA_W'(16'h0100 + i));
    end
    check_eq("ovf_count", count, DEPTH);
    check_eq("ovf_ready", sample_ready, 0);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_drops", drop_count, 3);
    hold_busy = 1'b0;
    wait_idle(2000);
    compare_sent();

    // Simultaneous push and pop at count=4, wrapping pointers 3x
    sent.delete(); expq.delete();
    rand_timing = 1'b1;
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = DATA_W'($urandom);
      push_word(w);
      expq.push_back(w);
    end
    n = 0;
    while (!wr_busy && n < 50) begin @(negedge clk); n++; end
    check_eq("pair_fill_busy", (n < 50), 1);
    check_eq("pair_fill_count", count, 4);
    prev = pops_req;
    hold_busy = 1'b0;
    #1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      n = 0;
      while (pops_req == prev && n < 200) begin @(negedge clk); #1; n++; end
      check_eq("pair_wait", (n < 200), 1);
      prev = pops_req;
      w = DATA_W'($urandom);
      sample_valid = 1'b1;
      sample_data  = w;
      expq.push_back(w);
      @(negedge clk); #1;
      sample_valid = 1'b0;
      check_eq("pair_count", count, 4);
    end
    @(negedge clk);
    wait_idle(500);
    compare_sent();

    // Random traffic, including drops into a full queue
    for (int c = 0; c < 600; c++) begin
      sample_valid = ($urandom_range(2, 0) == 0);
      sample_data  = DATA_W'($urandom);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    wait_idle(3000);
    rand_timing = 1'b0;

    // Acknowledge timeout and retry of the same word
    sent.delete();
    ack_mode = 1'b0;
    w = DATA_W'($urandom);
    push_word(w);
    n = 0;
    while (wr_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check_eq("to_first_launch", (n < 20), 1);
    check_eq("to_ack_err_pre", ack_err, 0);
    repeat (ACK_TIMEOUT) @(negedge clk);
    check_eq("to_ack_err_edge", ack_err, 0);
    @(negedge clk);
    check_eq("to_ack_err", ack_err, 1);
    check_eq("to_count", count, 1);
    ack_mode = 1'b1;
    busy_len = 3;
    @(negedge clk);
    check_eq("to_relaunch", wr_start, 1);
    check_eq("to_relaunch_word", wr_data, w);
    wait_idle(200);
    check_eq("to_sent_len", sent.size(), 2);
    if (sent.size() == 2) begin
      check_eq("to_sent0", sent[0], w);
      check_eq("to_sent1", sent[1], w);
    end

    // Reset during WAIT_DONE with six entries stored
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) push_word(DATA_W'($urandom));
    n = 0;
    while (!wr_busy && n < 50) begin @(negedge clk); n++; end
    check_eq("mid_busy", (n < 50), 1);
    check_eq("mid_count", count, 6);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_start", wr_start, 0);
    check_eq("mid_rst_wr_data", wr_data, 0);
    check_eq("mid_rst_overflow", overflow, 0);
    check_eq("mid_rst_drop", drop_count, 0);
    check_eq("mid_rst_ack_err", ack_err, 0);
    rst = 1'b0;
    hold_busy = 1'b0;
    l0 = launches;
    repeat (60) @(negedge clk);
    check_eq("mid_no_launch", launches - l0, 0);
    check_eq("mid_writer_idle", wr_busy, 0);
    check_eq("mid_ready", sample_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
